// File: rtl/sram_like_arbiter.sv
// Two-into-one sram-like arbiter: grant select with stall lock, in-order return routing via an ID FIFO.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking instead of data-first priority.
module sram_like_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,

  output logic        protocol_err
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic [PTR_W:0] DEPTH = MAX_OUTSTANDING[PTR_W:0];

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  src_e                 grant;
  src_e                 tie_src;
  logic                 lock;
  src_e                 lock_src;
  logic                 lock_nxt;
  src_e                 lock_src_nxt;

  logic [MAX_OUTSTANDING-1:0] id_mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 head_id;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign head_id = id_mem[rd_ptr];

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  src_e last_src;

  // On a tie the source not served last wins.
  assign tie_src = (last_src == SRC_INST) ? SRC_DATA : SRC_INST;

  always_ff @(posedge clk) begin
    if (rst)       last_src <= SRC_INST;
    else if (push) last_src <= grant;
  end
`else
  assign tie_src = SRC_DATA;
`endif

  always_comb begin
    grant = SRC_INST;
    if (lock)                      grant = lock_src;
    else if (inst_req && data_req) grant = tie_src;
    else if (data_req)             grant = SRC_DATA;
  end

  always_comb begin
    m_req   = (grant == SRC_DATA) ? (data_req & ~full) : (inst_req & ~full);
    m_wr    = (grant == SRC_DATA) ? data_wr    : inst_wr;
    m_size  = (grant == SRC_DATA) ? data_size  : inst_size;
    m_addr  = (grant == SRC_DATA) ? data_addr  : inst_addr;
    m_wdata = (grant == SRC_DATA) ? data_wdata : inst_wdata;
  end

  assign inst_addr_ok = m_addr_ok & (grant == SRC_INST) & ~full;
  assign data_addr_ok = m_addr_ok & (grant == SRC_DATA) & ~full;

  assign push = m_req & m_addr_ok;
  assign pop  = m_data_ok & ~empty;

  assign inst_data_ok = pop & ~head_id;
  assign data_data_ok = pop &  head_id;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  always_comb begin
    lock_nxt     = lock;
    lock_src_nxt = lock_src;
    if (push) begin
      lock_nxt = 1'b0;
    end else if (m_req) begin
      lock_nxt     = 1'b1;
      lock_src_nxt = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock     <= 1'b0;
      lock_src <= SRC_INST;
    end else begin
      lock     <= lock_nxt;
      lock_src <= lock_src_nxt;
    end
  end

  // Full is judged on the pre-pop count so data_ok never feeds addr_ok.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      id_mem       <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= grant;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W + 1)'(1);
      else if (!push && pop) count <= count - (PTR_W + 1)'(1);
      if (m_data_ok && empty) protocol_err <= 1'b1;
    end
  end

endmodule
